demux32_router: RTL and testbench

- Registered 1-to-2 router for 32-bit words; the counterpart of the 2:1 word selector.
- Takes one producer stream and steers each word, by SELECT, into one of two output holding registers.
- Each output has its own valid/ready handshake, so two consumers (e.g. register-file write-back path and data-memory write path) drain independently.
- Sits between the ALU/load result bus and the two sink units in the processor datapath.

---
 rtl/demux32_router.sv | 149 ++++++++++++++
 tb/tb_demux32_router.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux32_router.sv
// demux32_router -- registered 1-to-2 word router.
//
// Steers each accepted input word into one of two output holding slots,
// chosen by SELECT (0 -> OUT1, 1 -> OUT2). Each slot has its own
// valid/ready handshake, so the two consumers drain independently. A slot
// can be drained and refilled on the same edge, which gives 1 word/cycle
// per output. There is no combinational path from IN to OUT1/OUT2.
//
// Ports:
//   CLK                 rising-edge clock
//   RESET               asynchronous, active-low reset
//   IN[WIDTH-1:0]       input word
//   IN_VALID/IN_READY   producer handshake (IN_READY is combinational)
//   SELECT              destination of the word offered with IN
//   OUT1, OUT1_VALID, OUT1_READY   slot-1 data and handshake
//   OUT2, OUT2_VALID, OUT2_READY   slot-2 data and handshake
//   COUNT1, COUNT2      per-output delivered-word counters
//
// Build option: define DEMUX32_ROUTER_COUNT_EN to build the per-output
// transfer counters. Without it COUNT1/COUNT2 are tied to zero.

module demux32_router #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SELECT,
  output logic [WIDTH-1:0] OUT1,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY,
  output logic [WIDTH-1:0] OUT2,
  output logic             OUT2_VALID,
  input  logic             OUT2_READY,
  output logic [CNT_W-1:0] COUNT1,
  output logic [CNT_W-1:0] COUNT2
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state1_q, state1_d;
  slot_state_e      state2_q, state2_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;

  logic accept1, accept2;
  logic drain1, drain2;

  // A slot can take a new word when it is empty or is being drained at
  // this same edge; only the slot addressed by SELECT matters.
  always_comb begin
    IN_READY = 1'b0;
    if (SELECT) begin
      IN_READY = (state2_q == EMPTY) | OUT2_READY;
    end else begin
      IN_READY = (state1_q == EMPTY) | OUT1_READY;
    end
  end

  always_comb begin
    accept1 = IN_VALID & IN_READY & ~SELECT;
    accept2 = IN_VALID & IN_READY &  SELECT;
    drain1  = (state1_q == FULL) & OUT1_READY;
    drain2  = (state2_q == FULL) & OUT2_READY;
  end

  // Slot next-state: a refill wins over a drain, so a slot drained and
  // refilled on the same edge stays FULL holding the new word.
  always_comb begin
    state1_d = state1_q;
    data1_d  = data1_q;
    if (accept1) begin
      state1_d = FULL;
      data1_d  = IN;
    end else if (drain1) begin
      state1_d = EMPTY;
    end
  end

  always_comb begin
    state2_d = state2_q;
    data2_d  = data2_q;
    if (accept2) begin
      state2_d = FULL;
      data2_d  = IN;
    end else if (drain2) begin
      state2_d = EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state1_q <= EMPTY;
      state2_q <= EMPTY;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end

  assign OUT1       = data1_q;
  assign OUT2       = data2_q;
  assign OUT1_VALID = (state1_q == FULL);
  assign OUT2_VALID = (state2_q == FULL);

`ifdef DEMUX32_ROUTER_COUNT_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Counters wrap naturally modulo 2^CNT_W.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (drain1) begin
      cnt1_d = cnt1_q + 1'b1;
    end
    if (drain2) begin
      cnt2_d = cnt2_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign COUNT1 = cnt1_q;
  assign COUNT2 = cnt2_q;
`else
  assign COUNT1 = '0;
  assign COUNT2 = '0;
`endif

endmodule

// File: tb/tb_demux32_router.sv
// Testbench for demux32_router: directed stimulus with a queue-based
// scoreboard. The stimulus side pushes each accepted word into the queue of
// its destination slot; a separate monitor pops and compares on every
// output handshake.

module tb_demux32_router;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
`ifdef DEMUX32_ROUTER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [WIDTH-1:0] IN = '0;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic             SELECT = 1'b0;
  logic [WIDTH-1:0] OUT1;
  logic             OUT1_VALID;
  logic             OUT1_READY = 1'b0;
  logic [WIDTH-1:0] OUT2;
  logic             OUT2_VALID;
  logic             OUT2_READY = 1'b0;
  logic [CNT_W-1:0] COUNT1;
  logic [CNT_W-1:0] COUNT2;

  demux32_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN         (IN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .SELECT     (SELECT),
    .OUT1       (OUT1),
    .OUT1_VALID (OUT1_VALID),
    .OUT1_READY (OUT1_READY),
    .OUT2       (OUT2),
    .OUT2_VALID (OUT2_VALID),
    .OUT2_READY (OUT2_READY),
    .COUNT1     (COUNT1),
    .COUNT2     (COUNT2)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes at the
  // following posedge, so the word shown now must be the oldest expected.
  always @(negedge CLK) begin
    if (RESET) begin
      if (OUT1_VALID && OUT1_READY) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_unexpected: got %h expected none", OUT1);
        end else begin
          chk("out1_data", OUT1, q1.pop_front());
        end
      end
      if (OUT2_VALID && OUT2_READY) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL out2_unexpected: got %h expected none", OUT2);
        end else begin
          chk("out2_data", OUT2, q2.pop_front());
        end
      end
    end
  end

  // Offer one word; returns after the accepting edge (+1) with IN_VALID
  // still high so back-to-back calls stream on consecutive cycles.
  task automatic send(input logic [31:0] d, input logic s, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    IN = d;
    SELECT = s;
    IN_VALID = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (IN_READY) begin
        ok = 1'b1;
        if (s) q2.push_back(d);
        else q1.push_back(d);
      end else begin
        waits++;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no IN_READY expected IN_READY within 20 cycles for %h", d);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    #2;
    RESET = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Reset state and idle behaviour
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out1", OUT1, 32'h0);
    chk("rst_out2", OUT2, 32'h0);
    chk("rst_v1", {31'b0, OUT1_VALID}, 32'h0);
    chk("rst_v2", {31'b0, OUT2_VALID}, 32'h0);
    SELECT = 1'b0; #1;
    chk("rst_rdy_sel0", {31'b0, IN_READY}, 32'h1);
    SELECT = 1'b1; #1;
    chk("rst_rdy_sel1", {31'b0, IN_READY}, 32'h1);
    chk("rst_cnt1", {24'b0, COUNT1}, 32'h0);
    chk("rst_cnt2", {24'b0, COUNT2}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    SELECT = 1'b0; #1;
    chk("idle_rdy_sel0", {31'b0, IN_READY}, 32'h1);
    SELECT = 1'b1; #1;
    chk("idle_rdy_sel1", {31'b0, IN_READY}, 32'h1);

    // Single route, held under backpressure, then drained
    OUT1_READY = 1'b0; OUT2_READY = 1'b0;
    send(32'hDEADBEEF, 1'b0, w);
    idle(0);
    chk("single_out1", OUT1, 32'hDEADBEEF);
    chk("single_v1", {31'b0, OUT1_VALID}, 32'h1);
    chk("single_v2", {31'b0, OUT2_VALID}, 32'h0);
    repeat (5) begin
      @(negedge CLK);
      chk("hold_out1", OUT1, 32'hDEADBEEF);
      chk("hold_v1", {31'b0, OUT1_VALID}, 32'h1);
    end
    @(posedge CLK); #1;
    OUT1_READY = 1'b1;
    @(posedge CLK); #1;
    chk("drain_v1", {31'b0, OUT1_VALID}, 32'h0);
    OUT1_READY = 1'b0;

    // Backpressure on slot 2, redirect to slot 1
    send(32'h00000011, 1'b1, w);
    IN = 32'h00000022; SELECT = 1'b1; IN_VALID = 1'b1;
    #1;
    chk("bp_rdy", {31'b0, IN_READY}, 32'h0);
    @(posedge CLK); #1;
    chk("bp_out2_hold", OUT2, 32'h00000011);
    chk("bp_v2", {31'b0, OUT2_VALID}, 32'h1);
    SELECT = 1'b0; #1;
    chk("bp_rdy_sel0", {31'b0, IN_READY}, 32'h1);
    send(32'h00000022, 1'b0, w);
    idle(0);
    chk("bp_out1", OUT1, 32'h00000022);
    chk("bp_out2", OUT2, 32'h00000011);
    OUT1_READY = 1'b1; OUT2_READY = 1'b1;
    idle(2);
    chk("bp_drained_v1", {31'b0, OUT1_VALID}, 32'h0);
    chk("bp_drained_v2", {31'b0, OUT2_VALID}, 32'h0);

    // Streaming 1..10 at full rate on slot 1
    for (int i = 1; i <= 10; i++) begin
      send(i, 1'b0, w);
      chk("stream_wait", w, 0);
      chk("stream_out1", OUT1, i);
      chk("stream_v1", {31'b0, OUT1_VALID}, 32'h1);
    end
    idle(2);

    // Interleave between both slots
    send(32'hA0A0A0A0, 1'b0, w); chk("il_wait", w, 0);
    send(32'hB0B0B0B0, 1'b1, w); chk("il_wait", w, 0);
    send(32'hA1A1A1A1, 1'b0, w); chk("il_wait", w, 0);
    send(32'hB1B1B1B1, 1'b1, w); chk("il_wait", w, 0);
    idle(3);
    chk("il_q1_empty", q1.size(), 0);
    chk("il_q2_empty", q2.size(), 0);

    // Asynchronous reset with slot 1 full
    OUT1_READY = 1'b0;
    send(32'hCAFE0001, 1'b0, w);
    idle(0);
    chk("ar_v1_before", {31'b0, OUT1_VALID}, 32'h1);
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_v1", {31'b0, OUT1_VALID}, 32'h0);
    chk("ar_out1", OUT1, 32'h0);
    SELECT = 1'b0; #1;
    chk("ar_rdy", {31'b0, IN_READY}, 32'h1);
    q1.delete();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Counter wrap on OUT2
    do_reset();
    OUT1_READY = 1'b1; OUT2_READY = 1'b1;
    for (int i = 0; i < 255; i++) send(32'h1000 + i, 1'b1, w);
    idle(2);
    chk("cnt2_255", {24'b0, COUNT2}, CNT_EN ? 32'd255 : 32'd0);
    chk("cnt1_255", {24'b0, COUNT1}, 32'd0);
    send(32'h20FF, 1'b1, w);
    idle(2);
    chk("cnt2_wrap", {24'b0, COUNT2}, 32'd0);
    chk("cnt1_wrap", {24'b0, COUNT1}, 32'd0);
    send(32'h3000, 1'b0, w);
    idle(2);
    chk("cnt1_one", {24'b0, COUNT1}, CNT_EN ? 32'd1 : 32'd0);

    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
